// File: rtl/dmem_bridge_pkg.sv
// Shared constants for the data-memory bridge: pipeline macros reused from the
// core, bridge FSM state encodings and bus request levels.
package dmem_bridge_pkg;

    localparam logic [31:0] ZeroWord      = 32'h0000_0000;
    localparam logic        ChipEnable    = 1'b1;
    localparam logic        WriteEnable   = 1'b1;
    localparam logic        RstEnable     = 1'b1;

    localparam logic        BusReqEnable  = 1'b1;
    localparam logic        BusReqDisable = 1'b0;

    localparam logic [1:0]  DmemIdle      = 2'b00;
    localparam logic [1:0]  DmemBusy      = 2'b01;
    localparam logic [1:0]  DmemDone      = 2'b10;

    // The bus only sees word addresses; byte position is carried by the lane enables.
    function automatic logic [31:0] word_align(input logic [31:0] byte_addr);
        return {byte_addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/dmem_wdog.sv
// Loadable wait counter for the data-memory bridge. Counts BUSY cycles without
// an acknowledge and flags the cycle in which the timeout limit is reached.
module dmem_wdog
    import dmem_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam int unsigned         LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [CNT_W-1:0]    LAST   = CNT_W'(LAST_I);
    localparam logic                ARMED  = (TIMEOUT != 0);

    logic [CNT_W-1:0] cnt;

    // Clear on a new access, otherwise advance once per unacknowledged wait cycle.
    always_ff @(posedge clk) begin
        if (rst_n == RstEnable) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expire = ARMED && (cnt == LAST);

endmodule

// File: rtl/dmem_bridge.sv
// Data-memory bridge between the MEM stage and a req/ack bus. Turns MEM's
// single-cycle strobes into a held bus request, stalls the pipeline while the
// access is outstanding, returns load data for one DONE cycle and completes
// hung accesses with an error pulse.
module dmem_bridge
    import dmem_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_ce_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] mem_data_o,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic        stallreq_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i,
    output logic        bus_err_o
);

    logic [1:0]  state;
    logic [31:0] rdata_q;
    logic        abort_q;
    logic        abort_now;
    logic        launch;
    logic        busy;
    logic        expire;
    logic        cnt_en;

    assign busy      = (state == DmemBusy);
    assign launch    = (state == DmemIdle) && (mem_ce_i == ChipEnable) && !flush_i;
    // A flush arriving in the completion cycle cancels delivery just like an earlier one.
    assign abort_now = abort_q | flush_i;
    assign cnt_en    = busy && !bus_ack_i && !expire;

    dmem_wdog #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_wdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (launch),
        .en     (cnt_en),
        .expire (expire)
    );

    // Access sequencer: launch, wait for ack or timeout, then present the result.
    always_ff @(posedge clk) begin
        if (rst_n == RstEnable) begin
            state       <= DmemIdle;
            bus_req_o   <= BusReqDisable;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= ZeroWord;
            bus_sel_o   <= 4'b0000;
            bus_wdata_o <= ZeroWord;
            rdata_q     <= ZeroWord;
            abort_q     <= 1'b0;
            bus_err_o   <= 1'b0;
        end else begin
            bus_err_o <= 1'b0;
            case (state)
                DmemIdle: begin
                    if (launch) begin
                        bus_we_o    <= mem_we_i;
                        bus_addr_o  <= word_align(mem_addr_i);
                        bus_sel_o   <= mem_sel_i;
                        bus_wdata_o <= mem_data_i;
                        bus_req_o   <= BusReqEnable;
                        abort_q     <= 1'b0;
                        state       <= DmemBusy;
                    end
                end
                DmemBusy: begin
                    if (flush_i) begin
                        abort_q <= 1'b1;
                    end
                    if (bus_ack_i) begin
                        bus_req_o <= BusReqDisable;
                        if ((bus_we_o != WriteEnable) && !abort_now) begin
                            rdata_q <= bus_rdata_i;
                        end
                        state <= abort_now ? DmemIdle : DmemDone;
                    end else if (expire) begin
                        bus_req_o <= BusReqDisable;
                        bus_err_o <= 1'b1;
                        rdata_q   <= ZeroWord;
                        state     <= abort_now ? DmemIdle : DmemDone;
                    end
                end
                DmemDone: begin
                    if (!(stall_i && !flush_i)) begin
                        state <= DmemIdle;
                    end
                end
                default: begin
                    state <= DmemIdle;
                end
            endcase
        end
    end

    assign stallreq_o = launch | busy;
    assign mem_data_o = (state == DmemDone) ? rdata_q : ZeroWord;

endmodule

// File: tb/tb_dmem_bridge.sv
// Scoreboard bench for dmem_bridge: the stimulus process computes each
// access's expected bus request and MEM-side result from the access rules and
// queues them; a monitor compares whenever the bus request rises or completes.
module tb_dmem_bridge;

    localparam int unsigned TO = 8;

    logic        clk;
    logic        rst_n;
    logic        mem_ce_i;
    logic        mem_we_i;
    logic [31:0] mem_addr_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_data_i;
    logic [31:0] mem_data_o;
    logic        stall_i;
    logic        flush_i;
    logic        stallreq_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i;
    logic        bus_ack_i;
    logic        bus_err_o;

    dmem_bridge #(
        .TIMEOUT (TO),
        .CNT_W   (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_ce_i    (mem_ce_i),
        .mem_we_i    (mem_we_i),
        .mem_addr_i  (mem_addr_i),
        .mem_sel_i   (mem_sel_i),
        .mem_data_i  (mem_data_i),
        .mem_data_o  (mem_data_o),
        .stall_i     (stall_i),
        .flush_i     (flush_i),
        .stallreq_o  (stallreq_o),
        .bus_req_o   (bus_req_o),
        .bus_we_o    (bus_we_o),
        .bus_addr_o  (bus_addr_o),
        .bus_sel_o   (bus_sel_o),
        .bus_wdata_o (bus_wdata_o),
        .bus_rdata_i (bus_rdata_i),
        .bus_ack_i   (bus_ack_i),
        .bus_err_o   (bus_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        logic        done;
        logic        err;
        logic [31:0] data;
        int unsigned stalls;
        int unsigned hold;
    } rsp_t;

    req_t        req_q[$];
    rsp_t        rsp_q[$];
    int          errors = 0;
    int          checks = 0;
    logic        mon_en = 1'b0;
    logic [31:0] model_rdata = 32'h0;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One MEM access: bus answers on BUSY cycle ackcyc (beyond TO means never),
    // MEM holds the DONE result for 'hold' extra cycles, optional flush in BUSY.
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                           input logic [31:0] wd, input int unsigned ackcyc,
                           input logic [31:0] rd, input int unsigned hold, input logic flush);
        int unsigned busy_cycles;
        logic        timeout;
        logic        abort;
        req_t        r;
        rsp_t        s;
        busy_cycles = (ackcyc <= TO) ? ackcyc : TO;
        timeout     = (ackcyc > TO);
        abort       = flush && (busy_cycles >= 2);
        if (timeout) model_rdata = 32'h0;
        else if (!we && !abort) model_rdata = rd;
        r.we = we; r.addr = addr & 32'hFFFF_FFFC; r.sel = sel; r.wdata = wd;
        s.done = !abort; s.err = timeout; s.data = model_rdata;
        s.stalls = busy_cycles + 1; s.hold = abort ? 0 : hold;
        req_q.push_back(r);
        rsp_q.push_back(s);
        mem_ce_i = 1'b1; mem_we_i = we; mem_addr_i = addr; mem_sel_i = sel;
        mem_data_i = wd; flush_i = 1'b0; stall_i = 1'b0;
        step();
        for (int unsigned k = 1; k <= busy_cycles; k++) begin
            bus_ack_i   = (!timeout && k == ackcyc);
            bus_rdata_i = bus_ack_i ? rd : $urandom;
            flush_i     = abort && (k == 1);
            step();
        end
        bus_ack_i = 1'b0;
        flush_i   = 1'b0;
        if (abort) begin
            mem_ce_i = 1'b0;
            step();
        end else begin
            for (int unsigned h = 0; h < hold; h++) begin
                stall_i = 1'b1;
                step();
            end
            stall_i = 1'b0;
            step();
            mem_ce_i = 1'b0;
        end
    endtask

    // Reset asserted during the second BUSY cycle of an unanswered load.
    task automatic run_reset();
        req_t r;
        rsp_t s;
        model_rdata = 32'h0;
        r.we = 1'b0; r.addr = 32'h0000_0A00; r.sel = 4'b1111; r.wdata = 32'h0;
        s.done = 1'b0; s.err = 1'b0; s.data = 32'h0; s.stalls = 3; s.hold = 0;
        req_q.push_back(r);
        rsp_q.push_back(s);
        mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h0000_0A02;
        mem_sel_i = 4'b1111; mem_data_i = 32'h0;
        step();
        step();
        rst_n    = 1'b1;
        mem_ce_i = 1'b0;
        step();
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_bus_addr", {40'h0, bus_addr_o}, 72'h0);
        check("rst_stallreq", {71'h0, stallreq_o}, 72'h0);
        step();
    endtask

    // Monitor: bus request fields on every request cycle, result on completion.
    initial begin
        req_t        cur;
        rsp_t        s;
        logic        prev_req;
        int unsigned stall_cnt;
        int unsigned hold_left;
        logic [31:0] hold_data;
        prev_req = 1'b0; stall_cnt = 0; hold_left = 0; hold_data = 32'h0;
        cur.we = 1'b0; cur.addr = 32'h0; cur.sel = 4'h0; cur.wdata = 32'h0;
        wait (mon_en);
        forever begin
            @(negedge clk);
            if (bus_req_o) begin
                if (!prev_req) begin
                    if (req_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_req: got bus_req_o=1 expected no request");
                    end else begin
                        cur = req_q.pop_front();
                    end
                end
                check("bus_fields", {3'b0, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o},
                      {3'b0, cur.we, cur.addr, cur.sel, cur.wdata});
            end
            if (prev_req && !bus_req_o) begin
                if (rsp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: got completion expected none queued");
                end else begin
                    s = rsp_q.pop_front();
                    check("stall_cycles", 72'(stall_cnt), 72'(s.stalls));
                    check("done_err", {71'h0, bus_err_o}, {71'h0, s.err});
                    check("done_stallreq", {71'h0, stallreq_o}, 72'h0);
                    check("done_data", {40'h0, mem_data_o}, {40'h0, (s.done ? s.data : 32'h0)});
                    hold_left = s.hold;
                    hold_data = s.data;
                end
                stall_cnt = 0;
            end else begin
                check("no_spurious_err", {71'h0, bus_err_o}, 72'h0);
                if (hold_left > 0) begin
                    check("hold_data", {40'h0, mem_data_o}, {40'h0, hold_data});
                    check("hold_stallreq", {71'h0, stallreq_o}, 72'h0);
                    hold_left--;
                end
                if (stallreq_o) stall_cnt++;
            end
            prev_req = bus_req_o;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish within time limit expected completion");
        $fatal(1);
    end

    initial begin
        logic [3:0] sels [7];
        sels = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1100, 4'b0011, 4'b1111};
        rst_n = 1'b1; mem_ce_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = 32'h0;
        mem_sel_i = 4'h0; mem_data_i = 32'h0; stall_i = 1'b0; flush_i = 1'b0;
        bus_rdata_i = 32'h0; bus_ack_i = 1'b0;
        repeat (3) step();
        rst_n = 1'b0;
        @(negedge clk);
        check("reset_outputs", {bus_req_o, bus_we_o, bus_err_o, stallreq_o, bus_sel_o, bus_addr_o, bus_wdata_o},
              72'h0);
        check("reset_mem_data", {40'h0, mem_data_o}, 72'h0);
        mon_en = 1'b1;
        step();

        run_txn(1'b0, 32'h0000_0100, 4'b1000, 32'h0,        1,      32'hA1B2C3D4, 0, 1'b0);
        run_txn(1'b1, 32'h0000_0207, 4'b0001, 32'h0000_00EE, 6,     32'hDEADBEEF, 0, 1'b0);
        run_txn(1'b0, 32'h0000_003C, 4'b1111, 32'h0,        1,      32'h12345678, 3, 1'b0);
        run_txn(1'b0, 32'h0000_0040, 4'b1111, 32'h0,        TO + 1, 32'h99999999, 0, 1'b0);
        run_txn(1'b0, 32'h0000_0044, 4'b0100, 32'h0,        3,      32'h55AA55AA, 0, 1'b1);
        run_txn(1'b1, 32'h0000_0048, 4'b1111, 32'h11,       1,      32'h77777777, 0, 1'b0);
        run_txn(1'b0, 32'h0000_0051, 4'b0010, 32'h0,        TO,     32'hCAFEF00D, 1, 1'b0);

        for (int i = 0; i < 40; i++) begin
            run_txn(1'($urandom), $urandom, sels[$urandom_range(0, 6)], $urandom,
                    $urandom_range(1, TO + 2), $urandom, $urandom_range(0, 3),
                    ($urandom_range(0, 4) == 0));
            repeat ($urandom_range(0, 2)) step();
        end

        run_reset();
        run_txn(1'b0, 32'h0000_0C00, 4'b1111, 32'h0, 2, 32'h0BADF00D, 0, 1'b0);

        repeat (4) step();
        check("req_q_drained", 72'(req_q.size()), 72'h0);
        check("rsp_q_drained", 72'(rsp_q.size()), 72'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
